// File: rtl/rob_core.sv
// Reorder buffer: in-order allocate, out-of-order completion, in-order single retire per cycle.
// Optional feature: define ROB_RETIRE_STATS_EN to add the 32-bit retired_total counter output.
module rob_core #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [PREG_W-1:0] alloc_dr_p,
    input  logic [PREG_W-1:0] alloc_old_dr,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cmp0_valid,
    input  logic [IDX_W-1:0]  cmp0_idx,
    input  logic              cmp1_valid,
    input  logic [IDX_W-1:0]  cmp1_idx,
    output logic              retire_valid,
    output logic [IDX_W-1:0]  retire_idx,
    output logic [PREG_W-1:0] retire_dr_p,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg,
`ifdef ROB_RETIRE_STATS_EN
    output logic [31:0]       retired_total,
`endif
    output logic [IDX_W:0]    count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [PREG_W-1:0] dr_q  [DEPTH];
    logic [PREG_W-1:0] old_q [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              rv_q, rv_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [PREG_W-1:0] rdr_q, rdr_d;
    logic              fv_q, fv_d;
    logic [PREG_W-1:0] fp_q, fp_d;
    logic              do_alloc;
    logic              do_retire;

    // No look-through: a full ROB refuses allocation even if the head retires this edge.
    assign alloc_ready = (count_q != FULL_CNT);
    assign alloc_idx   = tail_q;
    assign do_alloc    = alloc_valid && alloc_ready;
    // Uses registered done, so an entry completed on this edge retires on the next one.
    assign do_retire   = valid_q[head_q] && done_q[head_q];

    assign retire_valid = rv_q;
    assign retire_idx   = ridx_q;
    assign retire_dr_p  = rdr_q;
    assign free_valid   = fv_q;
    assign free_preg    = fp_q;
    assign count        = count_q;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rv_d    = 1'b0;
        ridx_d  = ridx_q;
        rdr_d   = rdr_q;
        fv_d    = 1'b0;
        fp_d    = fp_q;
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cmp0_valid && valid_q[cmp0_idx]) done_d[cmp0_idx] = 1'b1;
            if (cmp1_valid && valid_q[cmp1_idx]) done_d[cmp1_idx] = 1'b1;
            if (do_alloc) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            if (do_retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
                rv_d            = 1'b1;
                ridx_d          = head_q;
                rdr_d           = dr_q[head_q];
                fv_d            = (old_q[head_q] != '0);
                fp_d            = old_q[head_q];
            end
            case ({do_alloc, do_retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rv_q    <= 1'b0;
            ridx_q  <= '0;
            rdr_q   <= '0;
            fv_q    <= 1'b0;
            fp_q    <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rv_q    <= rv_d;
            ridx_q  <= ridx_d;
            rdr_q   <= rdr_d;
            fv_q    <= fv_d;
            fp_q    <= fp_d;
        end
    end

    // Tag payload is only meaningful under a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!flush && do_alloc) begin
            dr_q[tail_q]  <= alloc_dr_p;
            old_q[tail_q] <= alloc_old_dr;
        end
    end

`ifdef ROB_RETIRE_STATS_EN
    logic [31:0] total_q;

    // Survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     total_q <= '0;
        else if (rv_d) total_q <= total_q + 32'd1;
    end

    assign retired_total = total_q;
`endif

endmodule

// File: tb/tb_rob_core.sv
// Bench for rob_core: retire-order scoreboard plus table-driven single-entry vectors and corner sequences.
module tb_rob_core;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic       alloc_valid;
    logic [5:0] alloc_dr_p;
    logic [5:0] alloc_old_dr;
    logic       alloc_ready;
    logic [3:0] alloc_idx;
    logic       cmp0_valid;
    logic [3:0] cmp0_idx;
    logic       cmp1_valid;
    logic [3:0] cmp1_idx;
    logic       retire_valid;
    logic [3:0] retire_idx;
    logic [5:0] retire_dr_p;
    logic       free_valid;
    logic [5:0] free_preg;
`ifdef ROB_RETIRE_STATS_EN
    logic [31:0] retired_total;
`endif
    logic [4:0] count;

    rob_core #(.DEPTH(16), .IDX_W(4), .PREG_W(6)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_dr_p   (alloc_dr_p),
        .alloc_old_dr (alloc_old_dr),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .cmp0_valid   (cmp0_valid),
        .cmp0_idx     (cmp0_idx),
        .cmp1_valid   (cmp1_valid),
        .cmp1_idx     (cmp1_idx),
        .retire_valid (retire_valid),
        .retire_idx   (retire_idx),
        .retire_dr_p  (retire_dr_p),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
`ifdef ROB_RETIRE_STATS_EN
        .retired_total(retired_total),
`endif
        .count        (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard entry: {idx[3:0], dr_p[5:0], old_dr[5:0]}
    logic [15:0] exp_q[$];
    logic [3:0]  m_tail;

    typedef struct {
        logic [5:0] dr_p;
        logic [5:0] old_dr;
        logic       use_cmp1;
        logic       exp_free;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_dr_p   = '0;
        alloc_old_dr = '0;
        cmp0_valid   = 1'b0;
        cmp0_idx     = '0;
        cmp1_valid   = 1'b0;
        cmp1_idx     = '0;
    endtask

    task automatic alloc_one(input logic [5:0] dr, input logic [5:0] old, input logic exp_accept);
        check("alloc_ready", 32'(alloc_ready), 32'(exp_accept));
        check("alloc_idx", 32'(alloc_idx), 32'(m_tail));
        alloc_valid  = 1'b1;
        alloc_dr_p   = dr;
        alloc_old_dr = old;
        if (exp_accept) exp_q.push_back({m_tail, dr, old});
        tick();
        alloc_valid = 1'b0;
        if (exp_accept) m_tail = m_tail + 4'd1;
    endtask

    task automatic complete(input int port, input logic [3:0] idx);
        if (port == 0) begin cmp0_valid = 1'b1; cmp0_idx = idx; end
        else           begin cmp1_valid = 1'b1; cmp1_idx = idx; end
        tick();
        cmp0_valid = 1'b0;
        cmp1_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        m_tail = '0;
    endtask

    task automatic expect_retire(input logic [3:0] idx);
        check("retire_valid", 32'(retire_valid), 32'd1);
        check("retire_idx", 32'(retire_idx), 32'(idx));
    endtask

    // scoreboard: retire pulses must match allocations in program order
    always @(negedge clk) begin
        if (rstn) begin
            if (retire_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_retire", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("sb_retire_idx", 32'(retire_idx), 32'(e[15:12]));
                    check("sb_retire_dr_p", 32'(retire_dr_p), 32'(e[11:6]));
                    check("sb_free_valid", 32'(free_valid), 32'(e[5:0] != 6'd0));
                    if (e[5:0] != 6'd0) check("sb_free_preg", 32'(free_preg), 32'(e[5:0]));
                end
            end else begin
                check("sb_free_without_retire", 32'(free_valid), 32'd0);
            end
        end
    end

    initial begin
        vecs[0] = '{dr_p: 6'd33, old_dr: 6'd5,  use_cmp1: 1'b0, exp_free: 1'b1};
        vecs[1] = '{dr_p: 6'd12, old_dr: 6'd0,  use_cmp1: 1'b1, exp_free: 1'b0};
        vecs[2] = '{dr_p: 6'd63, old_dr: 6'd63, use_cmp1: 1'b0, exp_free: 1'b1};
        vecs[3] = '{dr_p: 6'd1,  old_dr: 6'd2,  use_cmp1: 1'b1, exp_free: 1'b1};

        idle_inputs();
        m_tail = '0;
        rstn   = 1'b0;
        #1;
        check("rst_retire_valid", 32'(retire_valid), 32'd0);
        check("rst_free_valid", 32'(free_valid), 32'd0);
        check("rst_retire_idx", 32'(retire_idx), 32'd0);
        check("rst_retire_dr_p", 32'(retire_dr_p), 32'd0);
        check("rst_free_preg", 32'(free_preg), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
`ifdef ROB_RETIRE_STATS_EN
        check("rst_retired_total", retired_total, 32'd0);
`endif

        // single-entry alloc -> complete -> retire two edges after completion
        for (int i = 0; i < 4; i++) begin
            logic [3:0] idx;
            idx = m_tail;
            alloc_one(vecs[i].dr_p, vecs[i].old_dr, 1'b1);
            check("v_count_after_alloc", 32'(count), 32'd1);
            complete(vecs[i].use_cmp1 ? 1 : 0, idx);
            check("v_no_retire_on_cmp_edge", 32'(retire_valid), 32'd0);
            tick();
            expect_retire(idx);
            check("v_retire_dr_p", 32'(retire_dr_p), 32'(vecs[i].dr_p));
            check("v_free_valid", 32'(free_valid), 32'(vecs[i].exp_free));
            if (vecs[i].exp_free) check("v_free_preg", 32'(free_preg), 32'(vecs[i].old_dr));
            check("v_count_after_retire", 32'(count), 32'd0);
            tick();
            check("v_retire_one_cycle", 32'(retire_valid), 32'd0);
        end
`ifdef ROB_RETIRE_STATS_EN
        check("stats_after_vectors", retired_total, 32'd4);
`endif

        // fill to capacity, 17th alloc rejected, tail wraps
        do_flush();
        check("flush_count", 32'(count), 32'd0);
        check("flush_alloc_idx", 32'(alloc_idx), 32'd0);
        for (int i = 0; i < 16; i++) alloc_one(6'(10 + i), 6'(20 + i), 1'b1);
        check("full_count", 32'(count), 32'd16);
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_tail_wrap", 32'(alloc_idx), 32'd0);
        alloc_one(6'd55, 6'd56, 1'b0);
        check("full_17th_ignored", 32'(count), 32'd16);

        // full ROB, head done, alloc held: retire wins, alloc waits a cycle
        complete(0, 4'd0);
        alloc_valid  = 1'b1;
        alloc_dr_p   = 6'd50;
        alloc_old_dr = 6'd51;
        check("fr_ready_before", 32'(alloc_ready), 32'd0);
        tick();
        expect_retire(4'd0);
        check("fr_count_15", 32'(count), 32'd15);
        check("fr_ready_after", 32'(alloc_ready), 32'd1);
        exp_q.push_back({4'd0, 6'd50, 6'd51});
        tick();
        alloc_valid = 1'b0;
        check("fr_alloc_taken", 32'(count), 32'd16);
        check("fr_tail", 32'(alloc_idx), 32'd1);

        // out-of-order completion, in-order retire
        do_flush();
        alloc_one(6'd40, 6'd1, 1'b1);
        alloc_one(6'd41, 6'd0, 1'b1);
        alloc_one(6'd42, 6'd3, 1'b1);
        complete(0, 4'd2);
        check("ooo_hold_2", 32'(retire_valid), 32'd0);
        complete(1, 4'd1);
        check("ooo_hold_1", 32'(retire_valid), 32'd0);
        complete(0, 4'd0);
        check("ooo_hold_0", 32'(retire_valid), 32'd0);
        tick(); expect_retire(4'd0);
        tick(); expect_retire(4'd1);
        tick(); expect_retire(4'd2);
        tick();
        check("ooo_drained", 32'(retire_valid), 32'd0);
        check("ooo_count", 32'(count), 32'd0);

        // both ports on the same index
        alloc_one(6'd44, 6'd7, 1'b1);
        cmp0_valid = 1'b1; cmp0_idx = 4'd3;
        cmp1_valid = 1'b1; cmp1_idx = 4'd3;
        tick();
        cmp0_valid = 1'b0; cmp1_valid = 1'b0;
        tick();
        expect_retire(4'd3);

        // completion to an invalid entry is dropped
        complete(0, 4'd5);
        alloc_one(6'd45, 6'd8, 1'b1);
        alloc_one(6'd46, 6'd9, 1'b1);
        complete(1, 4'd4);
        tick();
        expect_retire(4'd4);
        tick();
        check("drop_no_retire_5", 32'(retire_valid), 32'd0);
        check("drop_count", 32'(count), 32'd1);
        complete(0, 4'd5);
        tick();
        expect_retire(4'd5);

        // flush beats completion, allocation and a pending retire
        do_flush();
        for (int i = 0; i < 5; i++) alloc_one(6'(20 + i), 6'(i + 1), 1'b1);
        check("pre_flush_count", 32'(count), 32'd5);
        complete(0, 4'd0);
        flush        = 1'b1;
        cmp0_valid   = 1'b1; cmp0_idx = 4'd1;
        alloc_valid  = 1'b1;
        alloc_dr_p   = 6'd60;
        alloc_old_dr = 6'd61;
        tick();
        idle_inputs();
        exp_q.delete();
        m_tail = '0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_tail", 32'(alloc_idx), 32'd0);
        check("fl_retire_valid", 32'(retire_valid), 32'd0);
        check("fl_free_valid", 32'(free_valid), 32'd0);
        tick();
        check("fl_no_late_retire", 32'(retire_valid), 32'd0);
`ifdef ROB_RETIRE_STATS_EN
        check("stats_kept_by_flush", retired_total, 32'd11);
`endif

        // reset mid-operation discards everything silently
        alloc_one(6'd30, 6'd2, 1'b1);
        alloc_one(6'd31, 6'd3, 1'b1);
        complete(0, 4'd0);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        m_tail = '0;
        check("mid_rst_retire_valid", 32'(retire_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ready", 32'(alloc_ready), 32'd1);
        check("mid_rst_tail", 32'(alloc_idx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        check("post_rst_no_retire", 32'(retire_valid), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
